// File: rtl/altair_serial_pkg.sv
// Shared definitions for the Altair serial receive path: frame geometry,
// source identifiers and the arbiter state encoding.
package altair_serial_pkg;

  localparam int FRAME_BITS = 10;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  // A grant (or shadow) covers the whole frame and releases mid-stop-bit.
  function automatic int hold_cycles(input int clk_div);
    return FRAME_BITS * clk_div - clk_div / 2;
  endfunction

endpackage

// File: rtl/rx_source_tracker.sv
// One receive source: 2-flop synchronizer, start-edge detect and the shadow
// counter that masks a rejected frame's data edges.
module rx_source_tracker
  import altair_serial_pkg::*;
#(
  parameter int HOLD_CYCLES = hold_cycles(5208)
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rxd_in,
  input  logic reject_in,
  output logic sync_out,
  output logic start_out,
  output logic eligible_out
);

  localparam int CNT_W = $clog2(HOLD_CYCLES);

  logic             s1;
  logic             s2;
  logic             s2_prev;
  logic [CNT_W-1:0] shadow_cnt;

  // Sync flops clear to 0 so a line already high at release shows only a
  // rising transition, never a false start.
  // NOTE: every register here uses <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s2_prev    <= 1'b0;
      shadow_cnt <= '0;
    end else begin
      s1      <= rxd_in;
      s2      <= s1;
      s2_prev <= s2;
      if (reject_in)
        shadow_cnt <= CNT_W'(HOLD_CYCLES - 1);
      else if (shadow_cnt != '0)
        shadow_cnt <= shadow_cnt - CNT_W'(1);
    end
  end

  assign sync_out     = s2;
  assign start_out    = !s2 && s2_prev;
  assign eligible_out = (shadow_cnt == '0);

endmodule

// File: rtl/serial_rx_arbiter.sv
// Character-granular arbiter sharing the CPU receive line between the
// external pin (A) and the terminal (B); one source owns a whole frame.
module serial_rx_arbiter
  import altair_serial_pkg::*;
#(
  parameter int CLK_DIV     = 5208,
  parameter int HOLD_CYCLES = hold_cycles(CLK_DIV)
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rxd_a_in,
  input  logic rxd_b_in,
  output logic rxd_out,
  output logic grant_a_out,
  output logic grant_b_out,
  output logic drop_a_out,
  output logic drop_b_out
);

  localparam int CNT_W = $clog2(HOLD_CYCLES);

  logic sync_a, sync_b;
  logic start_a, start_b;
  logic elig_a, elig_b;
  logic cand_a, cand_b;
  logic reject_a, reject_b;
  logic accept;
  src_t winner;

  arb_state_t       state;
  src_t             grant;
  src_t             last_grant;
  logic [CNT_W-1:0] hold_cnt;

  rx_source_tracker #(.HOLD_CYCLES(HOLD_CYCLES)) u_track_a (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rxd_in      (rxd_a_in),
    .reject_in   (reject_a),
    .sync_out    (sync_a),
    .start_out   (start_a),
    .eligible_out(elig_a)
  );

  rx_source_tracker #(.HOLD_CYCLES(HOLD_CYCLES)) u_track_b (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rxd_in      (rxd_b_in),
    .reject_in   (reject_b),
    .sync_out    (sync_b),
    .start_out   (start_b),
    .eligible_out(elig_b)
  );

  assign cand_a = start_a && elig_a;
  assign cand_b = start_b && elig_b;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    accept   = 1'b0;
    winner   = SRC_A;
    reject_a = 1'b0;
    reject_b = 1'b0;
    if (state == ST_IDLE) begin
      if (cand_a && cand_b) begin
        accept   = 1'b1;
        winner   = (last_grant == SRC_A) ? SRC_B : SRC_A;
        reject_a = (winner == SRC_B);
        reject_b = (winner == SRC_A);
      end else if (cand_a) begin
        accept = 1'b1;
        winner = SRC_A;
      end else if (cand_b) begin
        accept = 1'b1;
        winner = SRC_B;
      end
    end else begin
      // Only the non-owner can be rejected; the owner's edges are data bits.
      reject_a = cand_a && (grant == SRC_B);
      reject_b = cand_b && (grant == SRC_A);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= ST_IDLE;
      grant       <= SRC_A;
      last_grant  <= SRC_B;
      hold_cnt    <= '0;
      rxd_out     <= 1'b1;
      grant_a_out <= 1'b0;
      grant_b_out <= 1'b0;
      drop_a_out  <= 1'b0;
      drop_b_out  <= 1'b0;
    end else begin
      drop_a_out <= reject_a;
      drop_b_out <= reject_b;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_HOLD;
            grant       <= winner;
            hold_cnt    <= CNT_W'(HOLD_CYCLES - 1);
            rxd_out     <= (winner == SRC_A) ? sync_a : sync_b;
            grant_a_out <= (winner == SRC_A);
            grant_b_out <= (winner == SRC_B);
          end else begin
            rxd_out <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            state       <= ST_IDLE;
            last_grant  <= grant;
            rxd_out     <= 1'b1;
            grant_a_out <= 1'b0;
            grant_b_out <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - CNT_W'(1);
            rxd_out  <= (grant == SRC_A) ? sync_a : sync_b;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
